decode_execute_stage: RTL and testbench

- Stage directly downstream of the 8-bit instruction fetch. Consumes the fetched 8-bit InstructionCode and its PC, then decodes and executes it against an internal 8x8 register file.
- Outputs the write-back result and a jump redirect (taken flag + target PC) back to the fetch stage.
- Pipeline: IF/ID capture register -> decode/execute (combinational) -> WB register -> register-file write.

---
 rtl/decode_execute_stage.sv | 116 +++++++++++
 tb/tb_decode_execute_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// Decode/execute stage for the 8-bit core: IF/ID capture, combinational execute
// against an 8x8 register file, WB register, and a one-cycle jump redirect to fetch.
module decode_execute_stage #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        InstructionCode,
  input  logic              instr_valid,
  input  logic [7:0]        pc_in,
  output logic              jump_taken,
  output logic [7:0]        jump_target,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_JMP = 2'b10,
    OP_NOP = 2'b11
  } opcode_e;

  logic              ifid_valid_q, ifid_valid_d;
  logic [7:0]        ifid_instr_q;
  logic [7:0]        ifid_pc_q;
  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              jump_taken_q, jump_taken_d;
  logic [7:0]        jump_target_q, jump_target_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  opcode_e           opcode;
  logic [2:0]        rd, rs;
  logic [DATA_W-1:0] opRd, opRs;

  assign opcode = opcode_e'(ifid_instr_q[7:6]);
  assign rd     = ifid_instr_q[5:3];
  assign rs     = ifid_instr_q[2:0];

  // A pending WB entry has not reached the array yet, so it overrides the read.
  assign opRd = (wb_en_q && (wb_addr_q == rd)) ? wb_data_q : regs_q[rd];
  assign opRs = (wb_en_q && (wb_addr_q == rs)) ? wb_data_q : regs_q[rs];

  always_comb begin
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    jump_taken_d  = 1'b0;
    jump_target_d = jump_target_q;
    if (ifid_valid_q) begin
      case (opcode)
        OP_MOV: begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd;
          wb_data_d = opRs;
        end
        OP_ADD: begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd;
          wb_data_d = opRd + opRs;
        end
        OP_JMP: begin
          jump_taken_d  = 1'b1;
          jump_target_d = ifid_pc_q + {{2{ifid_instr_q[5]}}, ifid_instr_q[5:0]};
        end
        default: ;
      endcase
    end
    // The instruction arriving alongside a taken jump is on the wrong path.
    ifid_valid_d = instr_valid && !jump_taken_d;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      jump_taken_q  <= 1'b0;
      jump_target_q <= '0;
    end else begin
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= InstructionCode;
      ifid_pc_q     <= pc_in;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      jump_taken_q  <= jump_taken_d;
      jump_target_q <= jump_target_d;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(i);
    end else if (wb_en_q) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign jump_taken  = jump_taken_q;
  assign jump_target = jump_target_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: directed instructions push expected
// WB/jump results into queues that a negedge monitor drains and compares.
module tb_decode_execute_stage;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wb_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] InstructionCode;
  logic       instr_valid;
  logic [7:0] pc_in;
  logic       jump_taken;
  logic [7:0] jump_target;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  wb_t        wbQ[$];
  logic [7:0] jmpQ[$];
  wb_t        wbExp;
  logic [7:0] jmpExp;
  int         total = 0;
  int         bad   = 0;

  decode_execute_stage dut (
    .clk(clk), .Reset(Reset), .InstructionCode(InstructionCode),
    .instr_valid(instr_valid), .pc_in(pc_in), .jump_taken(jump_taken),
    .jump_target(jump_target), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] instr, input logic [7:0] pc, input logic valid);
    @(posedge clk);
    #1;
    InstructionCode = instr;
    pc_in           = pc;
    instr_valid     = valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 8'h00, 1'b0);
  endtask

  task automatic checkReg(input string name, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    checkOutput(name, dbg_data, exp);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    Reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
  endtask

  // Every WB entry or jump pulse the DUT shows must match the oldest expectation.
  always @(negedge clk) begin
    if (Reset) begin
      if (wb_en) begin
        if (wbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_wb: got addr %0d data %h expected no write", wb_addr, wb_data);
        end else begin
          wbExp = wbQ.pop_front();
          checkOutput("wb_addr", {5'b0, wb_addr}, {5'b0, wbExp.a});
          checkOutput("wb_data", wb_data, wbExp.d);
        end
      end
      if (jump_taken) begin
        if (jmpQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_jump: got target %h expected no jump", jump_target);
        end else begin
          jmpExp = jmpQ.pop_front();
          checkOutput("jump_target", jump_target, jmpExp);
        end
      end
    end
  end

  initial begin
    Reset           = 1'b0;
    InstructionCode = 8'h00;
    instr_valid     = 1'b0;
    pc_in           = 8'h00;
    dbg_addr        = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;

    @(negedge clk);
    checkOutput("reset_wb_en", {7'b0, wb_en}, 8'h00);
    checkOutput("reset_jump_taken", {7'b0, jump_taken}, 8'h00);
    checkOutput("reset_wb_data", wb_data, 8'h00);
    checkOutput("reset_jump_target", jump_target, 8'h00);
    checkReg("reset_R5", 3'd5, 8'h05);

    // MOV R1 <= R2
    wbQ.push_back('{a: 3'd1, d: 8'h02});
    applyStimulus(8'h0A, 8'h00, 1'b1);
    idle(3);
    checkReg("mov_R1", 3'd1, 8'h02);

    // ADD R3 <= R3+R4 twice, second result forwarded
    wbQ.push_back('{a: 3'd3, d: 8'h07});
    wbQ.push_back('{a: 3'd3, d: 8'h0B});
    applyStimulus(8'h5C, 8'h01, 1'b1);
    applyStimulus(8'h5C, 8'h02, 1'b1);
    idle(3);
    checkReg("add_R3", 3'd3, 8'h0B);

    // ADD R7 <= R7+R7 six times, wrapping at 256
    wbQ.push_back('{a: 3'd7, d: 8'h0E});
    wbQ.push_back('{a: 3'd7, d: 8'h1C});
    wbQ.push_back('{a: 3'd7, d: 8'h38});
    wbQ.push_back('{a: 3'd7, d: 8'h70});
    wbQ.push_back('{a: 3'd7, d: 8'hE0});
    wbQ.push_back('{a: 3'd7, d: 8'hC0});
    for (int i = 0; i < 6; i++) applyStimulus(8'h7F, 8'(i), 1'b1);
    idle(3);
    checkReg("add_R7", 3'd7, 8'hC0);

    // Restore R1=1 so a leaked squashed MOV would be visible
    doReset();
    checkReg("post_reset_R1", 3'd1, 8'h01);

    // JMP -2 from 0x10; following MOV is squashed
    jmpQ.push_back(8'h0E);
    applyStimulus(8'hBE, 8'h10, 1'b1);
    applyStimulus(8'h0A, 8'h11, 1'b1);
    idle(4);
    checkReg("squash1_R1", 3'd1, 8'h01);

    // JMP +5; squashed MOV, then MOV offered during the redirect is accepted
    jmpQ.push_back(8'h15);
    applyStimulus(8'h85, 8'h10, 1'b1);
    applyStimulus(8'h0A, 8'h11, 1'b1);
    checkReg("squash2_R1", 3'd1, 8'h01);
    wbQ.push_back('{a: 3'd1, d: 8'h02});
    applyStimulus(8'h0A, 8'h15, 1'b1);
    idle(4);
    checkReg("after_jump_R1", 3'd1, 8'h02);

    // Reset while the ADD sits in WB
    wbQ.push_back('{a: 3'd3, d: 8'h07});
    applyStimulus(8'h5C, 8'h20, 1'b1);
    idle(1);
    @(posedge clk);
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("midreset_wb_en", {7'b0, wb_en}, 8'h00);
    checkOutput("midreset_wb_data", wb_data, 8'h00);
    checkOutput("midreset_wb_addr", {5'b0, wb_addr}, 8'h00);
    checkOutput("midreset_jump_taken", {7'b0, jump_taken}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    idle(2);
    checkReg("midreset_R3", 3'd3, 8'h03);

    checkOutput("wbQ_drained", 8'(wbQ.size()), 8'h00);
    checkOutput("jmpQ_drained", 8'(jmpQ.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
